bcd_edit_counter: RTL and testbench

//  Parametrised N-digit decimal (BCD) counter for the clock/calendar datapath. Advances one step per

---
 rtl/bcd_cnt_pkg.sv | 55 +++++
 rtl/bcd_digit_cell.sv | 30 +++
 rtl/bcd_edit_counter.sv | 168 ++++++++++++++++
 tb/tb_bcd_edit_counter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_cnt_pkg.sv
// Shared types and helpers for the BCD edit counter.
// Holds the op encoding, the decoded-op struct and BCD/binary conversions.
package bcd_cnt_pkg;

  localparam int MAX_DIGITS = 6;
  localparam int BCD_W      = 4 * MAX_DIGITS;
  localparam int BIN_W      = 20;   // 999999 fits in 20 bits
  localparam int IDX_W      = 3;    // digit index 0..5

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_TICK,
    OP_INC,
    OP_DEC
  } op_e;

  typedef struct packed {
    op_e              op;
    logic [IDX_W-1:0] digit;
  } op_t;

  // Full-width BCD to binary; unused upper digits must be zero.
  function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [BCD_W-1:0] bcd);
    logic [BIN_W-1:0] acc;
    acc = '0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      acc = BIN_W'(acc * BIN_W'(10)) + BIN_W'(bcd[4*i +: 4]);
    end
    return acc;
  endfunction

  // Binary to full-width BCD, used to turn integer parameters into register values.
  function automatic logic [BCD_W-1:0] bin_to_bcd(input int value);
    int               v;
    logic [BCD_W-1:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // True when the two-digit BCD value tens:ones is a multiple of 4.
  function automatic logic bcd2_div4(input bcd_digit_t tens, input bcd_digit_t ones);
    if (tens[0]) begin
      return (ones == 4'd2) || (ones == 4'd6);
    end
    return (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the edit counter.
// ripple=1: counts up when carry_in is set and forwards a carry on 9->0.
// ripple=0: local edit, inc/dec wrap inside the digit and never carry out.
module bcd_digit_cell (
  input  logic [3:0] digit,
  input  logic       inc,
  input  logic       dec,
  input  logic       ripple,
  input  logic       carry_in,
  output logic [3:0] digit_next,
  output logic       carry_out
);

  logic step_up;
  logic step_dn;

  // Next digit value and ripple carry for the selected mode.
  always_comb begin
    step_up    = ripple ? carry_in : inc;
    step_dn    = ~ripple & dec;
    digit_next = digit;
    if (step_up) begin
      digit_next = (digit >= 4'd9) ? 4'd0 : digit + 4'd1;
    end else if (step_dn) begin
      digit_next = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
    end
    carry_out = ripple & carry_in & (digit >= 4'd9);
  end

endmodule

// File: rtl/bcd_edit_counter.sv
// N-digit BCD counter with tick advance, per-digit key editing and range limits.
// Key presses and ticks are decoded into op_reg on one edge and applied on the next.
// Optional feature macro: LEAP_FLAG_EN (Gregorian leap-year flag on ClkLeap, needs DIGITS>=4).
module bcd_edit_counter
  import bcd_cnt_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int MIN_VAL      = 0,
  parameter int MAX_VAL      = 9999,
  parameter int RESET_VAL    = 2019,
  parameter int POS_W        = 3,
  parameter int EDIT_POS_LSD = 7,
  parameter int SCREEN_ID    = 1,
  localparam int CNT_W       = $clog2(10**DIGITS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ClkTick,
  input  logic                KeyPlus,
  input  logic                KeyMinus,
  input  logic                EditMode,
  input  logic [POS_W-1:0]    EditPos,
  input  logic [1:0]          screen,
  output logic [4*DIGITS-1:0] count_bcd,
  output logic [CNT_W-1:0]    count_bin,
  output logic                carry,
  output logic                ClkLeap
);

  localparam logic [BCD_W-1:0]    MIN_BCD_FULL   = bin_to_bcd(MIN_VAL);
  localparam logic [BCD_W-1:0]    RESET_BCD_FULL = bin_to_bcd(RESET_VAL);
  localparam logic [4*DIGITS-1:0] MIN_BCD        = MIN_BCD_FULL[4*DIGITS-1:0];
  localparam logic [4*DIGITS-1:0] RESET_BCD      = RESET_BCD_FULL[4*DIGITS-1:0];
  localparam logic [BIN_W-1:0]    MIN_BIN        = BIN_W'(MIN_VAL);
  localparam logic [BIN_W-1:0]    MAX_BIN        = BIN_W'(MAX_VAL);
  localparam logic [BIN_W-1:0]    SPAN_BIN       = BIN_W'(MAX_VAL - MIN_VAL);
  localparam logic [POS_W:0]      LSD_POS        = (POS_W+1)'(EDIT_POS_LSD);
  localparam logic [1:0]          EDIT_SCREEN    = 2'(SCREEN_ID);

  if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("bcd_edit_counter: DIGITS must be 1..6");
  end
  if (RESET_VAL < MIN_VAL || RESET_VAL > MAX_VAL) begin : g_bad_reset
    $error("bcd_edit_counter: RESET_VAL outside MIN_VAL..MAX_VAL");
  end

  logic [4*DIGITS-1:0] count_reg;
  logic                carry_reg;
  logic                plus_hist_reg;
  logic                minus_hist_reg;
  op_t                 op_reg;
  op_t                 op_next;

  logic [4*DIGITS-1:0] cand_bcd;
  logic [DIGITS:0]     ripple_carry;
  logic [BCD_W-1:0]    count_pad;
  logic [BCD_W-1:0]    cand_pad;
  logic [BIN_W-1:0]    count_val;
  logic [BIN_W-1:0]    cand_val;
  logic                cand_in_range;
  logic [POS_W:0]      pos_diff;
  logic                pos_ok;
  logic                edit_ok;
  logic                plus_press;
  logic                minus_press;

  // Binary views of the current count and of the candidate next count.
  always_comb begin
    count_pad                 = '0;
    count_pad[4*DIGITS-1:0]   = count_reg;
    cand_pad                  = '0;
    cand_pad[4*DIGITS-1:0]    = cand_bcd;
    count_val                 = bcd_to_bin(count_pad);
    cand_val                  = bcd_to_bin(cand_pad);
    // Single unsigned compare: values below MIN wrap to a huge offset.
    cand_in_range             = (cand_val - MIN_BIN) <= SPAN_BIN;
  end

  // Edit qualification and key falling-edge detection feeding the op decoder.
  always_comb begin
    pos_diff    = LSD_POS - {1'b0, EditPos};
    pos_ok      = ~pos_diff[POS_W] && (int'(pos_diff) < DIGITS);
    edit_ok     = EditMode && (screen == EDIT_SCREEN) && pos_ok;
    plus_press  = plus_hist_reg & ~KeyPlus;
    minus_press = minus_hist_reg & ~KeyMinus;
    op_next     = '{op: OP_NONE, digit: '0};
    if (!EditMode && ClkTick) begin
      op_next.op = OP_TICK;
    end else if (edit_ok && plus_press) begin
      op_next.op    = OP_INC;
      op_next.digit = IDX_W'(pos_diff);
    end else if (edit_ok && minus_press) begin
      op_next.op    = OP_DEC;
      op_next.digit = IDX_W'(pos_diff);
    end
  end

  // Per-digit next-value cells; in tick mode the carry ripples up from digit 0.
  assign ripple_carry[0] = (op_reg.op == OP_TICK);
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic sel;
    assign sel = (op_reg.digit == IDX_W'(gi));
    bcd_digit_cell u_cell (
      .digit      (count_reg[4*gi +: 4]),
      .inc        (sel && (op_reg.op == OP_INC)),
      .dec        (sel && (op_reg.op == OP_DEC)),
      .ripple     (op_reg.op == OP_TICK),
      .carry_in   (ripple_carry[gi]),
      .digit_next (cand_bcd[4*gi +: 4]),
      .carry_out  (ripple_carry[gi+1])
    );
  end

  // Key history, op pipeline register and application of the pending op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg      <= RESET_BCD;
      carry_reg      <= 1'b0;
      plus_hist_reg  <= 1'b1;
      minus_hist_reg <= 1'b1;
      op_reg         <= '{op: OP_NONE, digit: '0};
    end else begin
      plus_hist_reg  <= KeyPlus;
      minus_hist_reg <= KeyMinus;
      op_reg         <= op_next;
      carry_reg      <= 1'b0;
      case (op_reg.op)
        OP_TICK: begin
          // All-nines overflow is treated as a wrap as well, so the count never leaves range.
          if ((count_val == MAX_BIN) || ripple_carry[DIGITS]) begin
            count_reg <= MIN_BCD;
            carry_reg <= 1'b1;
          end else begin
            count_reg <= cand_bcd;
          end
        end
        OP_INC, OP_DEC: begin
          if (cand_in_range) begin
            count_reg <= cand_bcd;
          end
        end
        default: ;
      endcase
    end
  end

  assign count_bcd = count_reg;
  assign count_bin = count_val[CNT_W-1:0];
  assign carry     = carry_reg;

`ifdef LEAP_FLAG_EN
  if (DIGITS < 4) begin : g_leap_err
    $error("bcd_edit_counter: LEAP_FLAG_EN requires DIGITS >= 4");
    assign ClkLeap = 1'b0;
  end else begin : g_leap
    logic lo_zero;
    // Leap rule on BCD digits: century years use the upper two digits instead.
    always_comb begin
      lo_zero = (count_reg[7:0] == 8'h00);
      ClkLeap = lo_zero ? bcd2_div4(count_reg[15:12], count_reg[11:8])
                        : bcd2_div4(count_reg[7:4], count_reg[3:0]);
    end
  end
`else
  assign ClkLeap = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_edit_counter.sv
// Directed bench for bcd_edit_counter: a default year counter (dut1) and
// a 1..12 range-limited instance (dut2) sharing clock, reset and screen.
module tb_bcd_edit_counter;

`ifdef LEAP_FLAG_EN
  localparam logic LEAP_2000 = 1'b1;
`else
  localparam logic LEAP_2000 = 1'b0;
`endif

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic [1:0]  screen = 2'd1;

  logic        tick1 = 1'b0, plus1 = 1'b1, minus1 = 1'b1, mode1 = 1'b0;
  logic [2:0]  pos1  = 3'd0;
  logic [15:0] bcd1;
  logic [13:0] bin1;
  logic        carry1, leap1;

  logic        tick2 = 1'b0, plus2 = 1'b1, minus2 = 1'b1, mode2 = 1'b0;
  logic [2:0]  pos2  = 3'd0;
  logic [15:0] bcd2;
  logic [13:0] bin2;
  logic        carry2, leap2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_edit_counter dut1 (
    .clk(clk), .reset(reset), .ClkTick(tick1), .KeyPlus(plus1), .KeyMinus(minus1),
    .EditMode(mode1), .EditPos(pos1), .screen(screen),
    .count_bcd(bcd1), .count_bin(bin1), .carry(carry1), .ClkLeap(leap1)
  );

  bcd_edit_counter #(.DIGITS(4), .MIN_VAL(1), .MAX_VAL(12), .RESET_VAL(2)) dut2 (
    .clk(clk), .reset(reset), .ClkTick(tick2), .KeyPlus(plus2), .KeyMinus(minus2),
    .EditMode(mode2), .EditPos(pos2), .screen(screen),
    .count_bcd(bcd2), .count_bin(bin2), .carry(carry2), .ClkLeap(leap2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    $display("[%0t] %s got=%0h exp=%0h", $time, tag, got, exp);
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One key press on the chosen dut; returns at the negedge after the op is applied.
  task automatic press(input bit sel2, input bit plus, input logic [2:0] pos);
    if (sel2) begin
      mode2 = 1'b1; pos2 = pos;
      if (plus) plus2 = 1'b0; else minus2 = 1'b0;
    end else begin
      mode1 = 1'b1; pos1 = pos;
      if (plus) plus1 = 1'b0; else minus1 = 1'b0;
    end
    @(negedge clk);
    plus1 = 1'b1; minus1 = 1'b1; plus2 = 1'b1; minus2 = 1'b1;
    @(negedge clk);
  endtask

  task automatic tick(input bit sel2);
    if (sel2) begin mode2 = 1'b0; tick2 = 1'b1; end
    else      begin mode1 = 1'b0; tick1 = 1'b1; end
    @(negedge clk);
    tick1 = 1'b0; tick2 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    check("rst_hold_bcd", 32'(bcd1), 32'h2019);
    reset = 1'b1;
    @(negedge clk);
    check("rst_bcd", 32'(bcd1), 32'h2019);
    check("rst_bin", 32'(bin1), 32'd2019);
    check("rst_carry", 32'(carry1), 32'd0);
    check("rst_leap", 32'(leap1), 32'd0);
    check("rst2_bcd", 32'(bcd2), 32'h0002);

    // Held plus on digit 1 gives exactly one step
    mode1 = 1'b1; pos1 = 3'd6; plus1 = 1'b0;
    repeat (10) @(negedge clk);
    check("hold_plus", 32'(bcd1), 32'h2029);
    plus1 = 1'b1;
    @(negedge clk);
    press(0, 0, 3'd6); check("dec_d1", 32'(bcd1), 32'h2019);
    press(0, 0, 3'd7); check("dec_d0", 32'(bcd1), 32'h2018);
    press(0, 1, 3'd7); check("inc_d0", 32'(bcd1), 32'h2019);
    press(0, 0, 3'd6); check("dec_d1_b", 32'(bcd1), 32'h2009);
    press(0, 0, 3'd6); check("dec_d1_wrap", 32'(bcd1), 32'h2099);
    press(0, 1, 3'd6); check("inc_nocarry", 32'(bcd1), 32'h2009);
    check("edit_carry", 32'(carry1), 32'd0);

    // Gating: ticks in edit mode, wrong screen, invalid position
    mode1 = 1'b1; tick1 = 1'b1;
    @(negedge clk); tick1 = 1'b0;
    repeat (2) @(negedge clk);
    check("tick_in_edit", 32'(bcd1), 32'h2009);
    screen = 2'd2;
    press(0, 1, 3'd7); @(negedge clk);
    check("screen_gate", 32'(bcd1), 32'h2009);
    screen = 2'd1;
    press(0, 1, 3'd3); @(negedge clk);
    check("pos_gate", 32'(bcd1), 32'h2009);

    // Walk to 9999 by edits
    press(0, 0, 3'd4); press(0, 0, 3'd4); press(0, 0, 3'd4);
    press(0, 0, 3'd5); press(0, 0, 3'd6);
    check("reach_9999", 32'(bcd1), 32'h9999);

    // Tick wrap with a single-cycle carry
    mode1 = 1'b0; tick1 = 1'b1;
    @(negedge clk); tick1 = 1'b0;
    check("wrap_pre_bcd", 32'(bcd1), 32'h9999);
    check("wrap_pre_carry", 32'(carry1), 32'd0);
    @(negedge clk);
    check("wrap_bcd", 32'(bcd1), 32'h0000);
    check("wrap_bin", 32'(bin1), 32'd0);
    check("wrap_carry", 32'(carry1), 32'd1);
    @(negedge clk);
    check("wrap_carry_off", 32'(carry1), 32'd0);

    // Century year and full ripple into 2000
    press(0, 1, 3'd4); press(0, 0, 3'd5);
    check("set_1900", 32'(bcd1), 32'h1900);
    check("leap_1900", 32'(leap1), 32'd0);
    press(0, 0, 3'd6); press(0, 0, 3'd7);
    check("set_1999", 32'(bcd1), 32'h1999);
    tick(0);
    check("ripple_bcd", 32'(bcd1), 32'h2000);
    check("ripple_bin", 32'(bin1), 32'd2000);
    check("ripple_carry", 32'(carry1), 32'd0);
    check("leap_2000", 32'(leap1), 32'(LEAP_2000));

    // Back-to-back events on consecutive cycles
    mode1 = 1'b1; pos1 = 3'd7; plus1 = 1'b0;
    @(negedge clk);
    plus1 = 1'b1; minus1 = 1'b0; pos1 = 3'd6;
    @(negedge clk);
    minus1 = 1'b1;
    check("b2b_first", 32'(bcd1), 32'h2001);
    @(negedge clk);
    check("b2b_second", 32'(bcd1), 32'h2091);

    // Range-limited instance
    press(1, 0, 3'd7); check("r_dec_1", 32'(bcd2), 32'h0001);
    press(1, 0, 3'd7); check("r_dec_0_rej", 32'(bcd2), 32'h0001);
    press(1, 1, 3'd6); check("r_set_11", 32'(bcd2), 32'h0011);
    press(1, 1, 3'd7); check("r_set_12", 32'(bcd2), 32'h0012);
    press(1, 1, 3'd7); check("r_13_rej", 32'(bcd2), 32'h0012);
    check("r_rej_carry", 32'(carry2), 32'd0);
    tick(1);
    check("r_wrap_bcd", 32'(bcd2), 32'h0001);
    check("r_wrap_carry", 32'(carry2), 32'd1);
    press(1, 1, 3'd6); check("r_set_11b", 32'(bcd2), 32'h0011);

    // Reset in the cycle after a press discards the pending op
    mode2 = 1'b1; pos2 = 3'd7; minus2 = 1'b0;
    @(negedge clk);
    minus2 = 1'b1; reset = 1'b0;
    #1;
    check("rst_mid_bcd2", 32'(bcd2), 32'h0002);
    check("rst_mid_bcd1", 32'(bcd1), 32'h2019);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_op_lost", 32'(bcd2), 32'h0002);
    check("rst_after_bin2", 32'(bin2), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
